imm_decode_pipe: RTL

Registered, parametrised immediate-decode stage between instruction fetch and execute in the single-cycle-to-pipelined RISC-V datapath. Accepts one instruction plus its PC per beat over a valid/ready handshake. Emits the sign-/zero-extended immediate, an immediate-format code, the PC-relative target, and an illegal-opcode flag. A two-entry skid buffer gives full throughput under backpressure, and a saturating counter tallies illegal instructions.

---
 rtl/imm_decode_pipe.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/imm_decode_pipe.sv
// Immediate-decode stage: decodes the RV immediate, its format and the
// PC-relative target, then registers the result behind a two-entry skid buffer.
module imm_decode_pipe #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [XLEN-1:0]  out_target,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_count
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_R    = 3'd7
    } fmt_t;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] target;
        fmt_t            fmt;
        logic            illegal;
    } beat_t;

    logic [11:0] i_raw;
    logic [11:0] s_raw;
    logic [12:0] b_raw;
    logic [20:0] j_raw;
    logic [31:0] u_raw;
    beat_t       dec;

    beat_t       or_q;
    beat_t       sr_q;
    logic        or_valid;
    logic        sr_valid;

    logic        drain;
    logic        accept;
    logic        or_valid_n;
    logic        sr_valid_n;
    logic        ld_or_in;
    logic        ld_or_sr;
    logic        ld_sr;

    assign i_raw = in_instr[31:20];
    assign s_raw = {in_instr[31:25], in_instr[11:7]};
    assign b_raw = {in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign j_raw = {in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
    assign u_raw = {in_instr[31:12], 12'h000};

    // Opcode decode into format, extended immediate and PC-relative target
    always_comb begin
        dec.fmt     = FMT_NONE;
        dec.imm     = '0;
        dec.illegal = 1'b0;
        case (in_instr[6:0])
            7'b0110111, 7'b0010111: begin
                dec.fmt = FMT_U;
                dec.imm = XLEN'($signed(u_raw));
            end
            7'b1101111: begin
                dec.fmt = FMT_J;
                dec.imm = XLEN'($signed(j_raw));
            end
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111: begin
                dec.fmt = FMT_I;
                dec.imm = XLEN'($signed(i_raw));
            end
            7'b1100011: begin
                dec.fmt = FMT_B;
                dec.imm = XLEN'($signed(b_raw));
            end
            7'b0100011: begin
                dec.fmt = FMT_S;
                dec.imm = XLEN'($signed(s_raw));
            end
            7'b0110011: begin
                dec.fmt = FMT_R;
            end
            7'b1110011: begin
                if (in_instr[14]) begin
                    dec.fmt = FMT_Z;
                    dec.imm = XLEN'(in_instr[19:15]);
                end else begin
                    dec.fmt = FMT_I;
                    dec.imm = XLEN'($signed(i_raw));
                end
            end
            7'b0011011: begin
                if (XLEN == 64) begin
                    dec.fmt = FMT_I;
                    dec.imm = XLEN'($signed(i_raw));
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            7'b0111011: begin
                if (XLEN == 64) begin
                    dec.fmt = FMT_R;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
        dec.target = in_pc + dec.imm;
    end

    assign drain  = or_valid & out_ready;
    assign accept = in_valid & in_ready;

    // Buffer control: SR refills OR on drain; otherwise inputs go to OR when it frees, else to SR
    always_comb begin
        or_valid_n = or_valid;
        sr_valid_n = sr_valid;
        ld_or_in   = 1'b0;
        ld_or_sr   = 1'b0;
        ld_sr      = 1'b0;
        if (flush) begin
            or_valid_n = 1'b0;
            sr_valid_n = 1'b0;
        end else if (drain && sr_valid) begin
            // in_ready is low whenever SR is full, so no accept can coincide here
            ld_or_sr   = 1'b1;
            sr_valid_n = 1'b0;
        end else if (accept && (!or_valid || drain)) begin
            ld_or_in   = 1'b1;
            or_valid_n = 1'b1;
        end else if (accept) begin
            ld_sr      = 1'b1;
            sr_valid_n = 1'b1;
        end else if (drain) begin
            or_valid_n = 1'b0;
        end
    end

    // Buffer registers; in_ready is kept as its own flop mirroring !SR_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_valid <= 1'b0;
            sr_valid <= 1'b0;
            in_ready <= 1'b1;
            or_q     <= '0;
            sr_q     <= '0;
        end else begin
            or_valid <= or_valid_n;
            sr_valid <= sr_valid_n;
            in_ready <= !sr_valid_n;
            if (ld_or_in) or_q <= dec;
            if (ld_or_sr) or_q <= sr_q;
            if (ld_sr)    sr_q <= dec;
        end
    end

    // Saturating tally of illegal beats actually consumed downstream
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_count <= '0;
        end else if (!flush && drain && or_q.illegal && (illegal_count != '1)) begin
            illegal_count <= illegal_count + CNT_W'(1);
        end
    end

    assign out_valid   = or_valid;
    assign out_imm     = or_q.imm;
    assign out_fmt     = or_q.fmt;
    assign out_target  = or_q.target;
    assign out_illegal = or_q.illegal;

endmodule
